multi_wave_nco: RTL and testbench

- Parametrised numerically-controlled waveform generator, successor to the single-LUT ECG source in the signal-generator test bench.
- Combines a phase accumulator with runtime mode select: sawtooth, triangle, square with programmable duty, or an external LUT (ECG/arbitrary) read port.
- Adds per-sample enable, frequency changes applied only at the period boundary, phase offset and sync, signed gain, DC offset with saturation, and a valid-qualified pipelined output.
- Feeds the audio DAC / FIR test path.

---
 rtl/multi_wave_nco.sv | 177 +++++++++++++++++
 tb/tb_multi_wave_nco.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_wave_nco.sv
// Multi-waveform NCO: phase accumulator feeding saw/triangle/square/external-LUT generation,
// followed by signed gain, DC offset and saturation. Five-register pipeline, one sample per clock.
module multi_wave_nco #(
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned OUT_W  = 16,
   parameter int unsigned GAIN_W = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sample_en,
   input  logic [ACC_W-1:0]         phase_step,
   input  logic                     phase_sync,
   input  logic [ADDR_W-1:0]        phase_ofs,
   input  logic [1:0]               mode,
   input  logic [ADDR_W-1:0]        duty,
   input  logic [GAIN_W-1:0]        gain,
   input  logic signed [OUT_W-1:0]  dc_ofs,
   output logic [ADDR_W-1:0]        lut_addr,
   input  logic signed [OUT_W-1:0]  lut_data,
   output logic signed [OUT_W-1:0]  wave_out,
   output logic                     wave_valid,
   output logic                     cycle_start
);

   typedef enum logic [1:0] {ModeSaw = 2'd0, ModeTri = 2'd1, ModeSquare = 2'd2, ModeLut = 2'd3}
      mode_e;

   localparam int unsigned Shift = OUT_W - ADDR_W;
   localparam int unsigned PW    = OUT_W + GAIN_W + 1;

   localparam logic [OUT_W-1:0] MsbOnly = {1'b1, {(OUT_W - 1){1'b0}}};
   localparam logic [OUT_W-1:0] MaxPos  = ~MsbOnly;
   localparam logic [OUT_W-1:0] NegMax  = MsbOnly | OUT_W'(1);
   localparam logic signed [PW:0] SatHi = $signed({{(PW + 1 - OUT_W){1'b0}}, MaxPos});
   localparam logic signed [PW:0] SatLo = $signed({{(PW + 1 - OUT_W){1'b1}}, MsbOnly});

   // Stage 0: accumulator
   logic [ACC_W-1:0] acc_q, step_active_q, eff_c;
   logic [ACC_W:0]   acc_sum_c;
   logic             load_pend_q, v0_q, wrap0_q;
   mode_e            mode0_q;

   always_comb begin
      eff_c     = load_pend_q ? phase_step : step_active_q;
      acc_sum_c = {1'b0, acc_q} + {1'b0, eff_c};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q         <= '0;
         step_active_q <= '0;
         load_pend_q   <= 1'b1;
         v0_q          <= 1'b0;
         wrap0_q       <= 1'b0;
         mode0_q       <= ModeSaw;
      end else if (phase_sync) begin
         acc_q       <= '0;
         load_pend_q <= 1'b1;
         v0_q        <= 1'b0;
      end else if (sample_en) begin
         acc_q <= acc_sum_c[ACC_W-1:0];
         // New frequency word is only adopted at a period boundary
         if (load_pend_q || acc_sum_c[ACC_W]) step_active_q <= phase_step;
         load_pend_q <= 1'b0;
         v0_q        <= 1'b1;
         wrap0_q     <= acc_sum_c[ACC_W] | load_pend_q;
         mode0_q     <= mode_e'(mode);
      end else begin
         v0_q <= 1'b0;
      end
   end

   // Stage 1: address and synthetic waveform
   logic [ADDR_W-1:0]       p_c, tsrc_c, t_c, lut_addr_q;
   logic [OUT_W-1:0]        u_c, tu_c;
   logic signed [OUT_W-1:0] syn_c, syn1_q;
   logic                    v1_q, wrap1_q;
   mode_e                   mode1_q;

   always_comb begin
      p_c    = acc_q[ACC_W-1 -: ADDR_W] + phase_ofs;
      u_c    = OUT_W'(p_c) << Shift;
      // Upper half folds back: 2*(2^ADDR_W-1-p) == 2*~p
      tsrc_c = p_c[ADDR_W-1] ? ~p_c : p_c;
      t_c    = {tsrc_c[ADDR_W-2:0], 1'b0};
      tu_c   = OUT_W'(t_c) << Shift;
      case (mode0_q)
         ModeSaw:    syn_c = $signed(u_c ^ MsbOnly);
         ModeTri:    syn_c = $signed(tu_c ^ MsbOnly);
         ModeSquare: syn_c = (p_c < duty) ? $signed(MaxPos) : $signed(NegMax);
         default:    syn_c = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_addr_q <= '0;
         syn1_q     <= '0;
         v1_q       <= 1'b0;
         wrap1_q    <= 1'b0;
         mode1_q    <= ModeSaw;
      end else begin
         v1_q <= v0_q;
         if (v0_q) begin
            lut_addr_q <= p_c;
            syn1_q     <= syn_c;
            wrap1_q    <= wrap0_q;
            mode1_q    <= mode0_q;
         end
      end
   end

   // Stage 2: LUT capture; Stage 3: source select
   logic signed [OUT_W-1:0] lut_q, syn2_q, sel_q;
   logic                    v2_q, wrap2_q, v3_q, wrap3_q;
   mode_e                   mode2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_q   <= '0;
         syn2_q  <= '0;
         v2_q    <= 1'b0;
         wrap2_q <= 1'b0;
         mode2_q <= ModeSaw;
         sel_q   <= '0;
         v3_q    <= 1'b0;
         wrap3_q <= 1'b0;
      end else begin
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (v1_q) begin
            lut_q   <= lut_data;
            syn2_q  <= syn1_q;
            wrap2_q <= wrap1_q;
            mode2_q <= mode1_q;
         end
         if (v2_q) begin
            sel_q   <= (mode2_q == ModeLut) ? lut_q : syn2_q;
            wrap3_q <= wrap2_q;
         end
      end
   end

   // Stage 4: gain, offset, saturation
   logic signed [PW-1:0]    prod_c, scaled_c;
   logic signed [PW:0]      sum_c;
   logic signed [OUT_W-1:0] sat_c, wave_out_q;
   logic                    valid_q, cs_q;

   always_comb begin
      prod_c   = sel_q * $signed({1'b0, gain});
      scaled_c = prod_c >>> (GAIN_W - 1);
      sum_c    = {scaled_c[PW-1], scaled_c} + {{(PW + 1 - OUT_W){dc_ofs[OUT_W-1]}}, dc_ofs};
      if (sum_c > SatHi)      sat_c = $signed(MaxPos);
      else if (sum_c < SatLo) sat_c = $signed(MsbOnly);
      else                    sat_c = sum_c[OUT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wave_out_q <= '0;
         valid_q    <= 1'b0;
         cs_q       <= 1'b0;
      end else begin
         valid_q <= v3_q;
         cs_q    <= v3_q & wrap3_q;
         if (v3_q) wave_out_q <= sat_c;
      end
   end

   assign lut_addr    = lut_addr_q;
   assign wave_out    = wave_out_q;
   assign wave_valid  = valid_q;
   assign cycle_start = cs_q;

endmodule

// File: tb/tb_multi_wave_nco.sv
// Directed bench for multi_wave_nco: streams samples through each mode and checks every output
// against a formula model of the expected phase sequence, waveform, scaling and saturation.
module tb_multi_wave_nco;

   logic               clk;
   logic               rst_n;
   logic               sample_en;
   logic [31:0]        phase_step;
   logic               phase_sync;
   logic [9:0]         phase_ofs;
   logic [1:0]         mode;
   logic [9:0]         duty;
   logic [15:0]        gain;
   logic signed [15:0] dc_ofs;
   logic [9:0]         lut_addr;
   logic signed [15:0] lut_data;
   logic signed [15:0] wave_out;
   logic               wave_valid;
   logic               cycle_start;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   int     model_p;
   int     model_inc;
   bit     model_first;
   int     drv_inc;
   longint last_out;

   multi_wave_nco #(
      .ACC_W (32),
      .ADDR_W(10),
      .OUT_W (16),
      .GAIN_W(16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sample_en),
      .phase_step (phase_step),
      .phase_sync (phase_sync),
      .phase_ofs  (phase_ofs),
      .mode       (mode),
      .duty       (duty),
      .gain       (gain),
      .dc_ofs     (dc_ofs),
      .lut_addr   (lut_addr),
      .lut_data   (lut_data),
      .wave_out   (wave_out),
      .wave_valid (wave_valid),
      .cycle_start(cycle_start)
   );

   // ROM: data follows address combinationally, the DUT samples it one clock later
   assign lut_data = {2'b00, lut_addr, 4'b0000};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model(input int m, input int pa);
      longint raw, s;
      case (m)
         0:       raw = longint'(pa) * 64 - 32768;
         1:       raw = ((pa < 512) ? 128 * longint'(pa) : 128 * longint'(1023 - pa)) - 32768;
         2:       raw = (pa < int'(duty)) ? 32767 : -32767;
         default: raw = 16 * longint'(pa);
      endcase
      s = ((raw * longint'(gain)) >>> 15) + longint'(dc_ofs);
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
   endfunction

   // Drives nsamp back-to-back samples, then drains; mode switches after sample sw_at and the
   // driven step word switches to inc_b (units of 2^22) after sample step_at.
   task automatic stream(input int nsamp, input int sw_at, input int m_a, input int m_b,
                         input int step_at, input int inc_b);
      int n, ps, sum, pa, mn;
      bit cs;
      longint ex;
      for (int e = 1; e <= nsamp + 4; e++) begin
         if (e <= nsamp) begin
            sample_en  = 1'b1;
            mode       = 2'((e <= sw_at) ? m_a : m_b);
            phase_step = 32'((e > step_at) ? inc_b : drv_inc) << 22;
         end else begin
            sample_en = 1'b0;
         end
         tick();
         if (e > 4) begin
            n  = e - 4;
            ps = (n > step_at) ? inc_b : drv_inc;
            if (model_first) model_inc = ps;
            sum     = model_p + model_inc;
            cs      = (sum >= 1024) || model_first;
            model_p = sum % 1024;
            if (cs) model_inc = ps;
            model_first = 1'b0;
            mn = (n <= sw_at) ? m_a : m_b;
            pa = (model_p + int'(phase_ofs)) % 1024;
            ex = model(mn, pa);
            check("valid", 64'(wave_valid), 1);
            check("wave_out", 64'(wave_out), ex);
            check("cycle_start", 64'(cycle_start), 64'(cs));
            last_out = ex;
         end else begin
            check("latency_valid", 64'(wave_valid), 0);
            check("hold_out", 64'(wave_out), last_out);
         end
      end
      if (nsamp > step_at) drv_inc = inc_b;
      tick();
      check("idle_valid", 64'(wave_valid), 0);
      check("idle_hold", 64'(wave_out), last_out);
   endtask

   task automatic do_sync(input logic with_en);
      phase_sync = 1'b1;
      sample_en  = with_en;
      tick();
      phase_sync  = 1'b0;
      sample_en   = 1'b0;
      model_p     = 0;
      model_first = 1'b1;
   endtask

   initial begin
      rst_n       = 1'b0;
      sample_en   = 1'b0;
      phase_step  = 32'h0040_0000;
      phase_sync  = 1'b0;
      phase_ofs   = '0;
      mode        = 2'd0;
      duty        = '0;
      gain        = 16'h8000;
      dc_ofs      = '0;
      model_p     = 0;
      model_inc   = 1;
      model_first = 1'b1;
      drv_inc     = 1;
      last_out    = 0;

      #2;
      check("rst_wave_out", 64'(wave_out), 0);
      check("rst_valid", 64'(wave_valid), 0);
      check("rst_cycle_start", 64'(cycle_start), 0);
      check("rst_lut_addr", 64'(lut_addr), 0);
      #10 rst_n = 1'b1;

      // Sawtooth, one full period plus a wrap: -32704, -32640, ...
      stream(1026, 100000, 0, 0, 100000, 1);
      check("saw_last", 64'(wave_out), -32768 + 2 * 64);

      // Single-sample pulse
      stream(1, 100000, 0, 0, 100000, 1);
      check("pulse_out", 64'(wave_out), -32768 + 3 * 64);

      // Square with duty 256, switched to triangle after sample 260
      do_sync(1'b0);
      duty = 10'd256;
      stream(300, 260, 2, 1, 100000, 1);
      check("tri_last", 64'(wave_out), 128 * 300 - 32768);

      // Max gain plus DC offset: saturates at both ends of the ramp
      gain   = 16'hFFFF;
      dc_ofs = 16'sd16384;
      stream(724, 100000, 0, 0, 100000, 1);
      check("sat_low", 64'(wave_out), -32768);
      gain   = 16'h8000;
      dc_ofs = '0;

      // Step doubles at p = 100; takes effect only after the wrap
      stream(1030, 100000, 0, 0, 100, 2);
      check("step2_last", 64'(wave_out), 12 * 64 - 32768);

      // Sync with simultaneous sample_en, then LUT mode from p = 1
      drv_inc = 1;
      phase_step = 32'h0040_0000;
      do_sync(1'b1);
      stream(20, 100000, 3, 3, 100000, 1);
      check("lut_last", 64'(wave_out), 16 * 20);

      // Reset in the middle of a running stream
      mode       = 2'd3;
      sample_en  = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("pre_reset_valid", 64'(wave_valid), 1);
      rst_n     = 1'b0;
      sample_en = 1'b0;
      #1;
      check("mid_rst_wave_out", 64'(wave_out), 0);
      check("mid_rst_valid", 64'(wave_valid), 0);
      check("mid_rst_cycle_start", 64'(cycle_start), 0);
      check("mid_rst_lut_addr", 64'(lut_addr), 0);
      #10 rst_n = 1'b1;
      model_p     = 0;
      model_first = 1'b1;
      last_out    = 0;

      // After reset, LUT mode with a half-period phase offset
      phase_ofs = 10'd512;
      stream(12, 100000, 3, 3, 100000, 1);
      check("ofs_last", 64'(wave_out), 16 * 524);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
